// File: rtl/gon_scan_cfg_ctrl.sv
// Loads a flat ID table into the multicast-controller ID scan chain, MSB first.
// Optional macro GON_SCAN_READBACK_EN adds old_ids, capturing the previous chain contents from so_id.
module gon_scan_cfg_ctrl #(
  parameter int NUM_MCC   = 12,
  parameter int TAG_WIDTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [NUM_MCC*TAG_WIDTH-1:0]   ids_in,
  input  logic                           hold,
  input  logic                           so_id,
  output logic                           se_id,
  output logic                           si_id,
  output logic                           busy,
  output logic                           done,
  output logic                           ids_valid
`ifdef GON_SCAN_READBACK_EN
  ,
  output logic [NUM_MCC*TAG_WIDTH-1:0]   old_ids
`endif
);

  localparam int L  = NUM_MCC * TAG_WIDTH;
  localparam int CW = $clog2(L + 1);
  localparam int SW = (L > 1) ? $clog2(L) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(L - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [L-1:0]    shadow_q, shadow_d;
  logic            ids_valid_q, ids_valid_d;
  logic [SW-1:0]   sel;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shadow_d    = shadow_q;
    ids_valid_d = ids_valid_q;
    se_id       = 1'b0;
    si_id       = 1'b0;
    done        = 1'b0;
    sel         = SW'(LAST_CNT - cnt_q);
    case (state_q)
      IDLE: begin
        if (start) begin
          shadow_d    = ids_in;
          cnt_d       = '0;
          ids_valid_d = 1'b0;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        // si_id tracks cnt, so it stays put while hold freezes the counter
        si_id = shadow_q[sel];
        if (!hold) begin
          se_id = 1'b1;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_CNT) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        done        = 1'b1;
        ids_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shadow_q    <= '0;
      ids_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      ids_valid_q <= ids_valid_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign ids_valid = ids_valid_q;

`ifdef GON_SCAN_READBACK_EN
  logic [L-1:0] old_ids_q, old_ids_d;

  // First bit out of the chain is the last position, so after L shifts bit k holds old position k
  always_comb begin
    old_ids_d = old_ids_q;
    if (se_id) begin
      old_ids_d = {old_ids_q[L-2:0], so_id};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      old_ids_q <= '0;
    end else begin
      old_ids_q <= old_ids_d;
    end
  end

  assign old_ids = old_ids_q;
`else
  logic unused_so_id;
  assign unused_so_id = so_id;
`endif

endmodule

// File: tb/tb_gon_scan_cfg_ctrl.sv
// Directed testbench for gon_scan_cfg_ctrl with an 8-bit chain (NUM_MCC=2, TAG_WIDTH=4).
// Define GON_SCAN_READBACK_EN here too to exercise old_ids.
module tb_gon_scan_cfg_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] idsIn;
  logic       hold;
  logic       soId;
  logic       seId;
  logic       siId;
  logic       busy;
  logic       done;
  logic       idsValid;
`ifdef GON_SCAN_READBACK_EN
  logic [7:0] oldIds;
`endif

  logic [7:0] chainModel;
  int         checks;
  int         errors;

  gon_scan_cfg_ctrl #(
    .NUM_MCC   (2),
    .TAG_WIDTH (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .ids_in    (idsIn),
    .hold      (hold),
    .so_id     (soId),
    .se_id     (seId),
    .si_id     (siId),
    .busy      (busy),
    .done      (done),
    .ids_valid (idsValid)
`ifdef GON_SCAN_READBACK_EN
    ,
    .old_ids   (oldIds)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model of the external ID chain: position 0 fed by si_id, so_id from position 7
  initial chainModel = 8'h00;
  always @(posedge clk) begin
    if (seId) chainModel <= {chainModel[6:0], siId};
  end
  assign soId = chainModel[7];

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic h, input logic [7:0] ids);
    start = s;
    hold  = h;
    idsIn = ids;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Drives one load starting now (posedge+1); optionally holds and pulses a spurious start with 8'hFF
  task automatic runLoad(input logic [7:0] ids, input int holdAfter, input int holdLen,
                         input bit injectStart, input int expDoneCycle);
    int   shifts;
    int   held;
    bit   sawDone;
    logic h;
    applyStimulus(1'b1, 1'b0, ids);
    @(negedge clk);
    checkOutput("busy_before_start", busy, 1'b0);
    nextCycle();
    shifts  = 0;
    held    = 0;
    sawDone = 0;
    for (int cyc = 1; cyc <= 30 && !sawDone; cyc++) begin
      h = (shifts == holdAfter) && (held < holdLen);
      applyStimulus(injectStart && (cyc == 3), h, injectStart ? 8'hFF : ids);
      @(negedge clk);
      if (shifts < 8) begin
        checkOutput("se_id", seId, !h);
        checkOutput("si_id", siId, ids[3'(7 - shifts)]);
        checkOutput("busy_shift", busy, 1'b1);
        checkOutput("done_early", done, 1'b0);
        if (h) held++;
        else shifts++;
      end else begin
        checkOutput("done_cycle", cyc, expDoneCycle);
        checkOutput("done", done, 1'b1);
        checkOutput("se_id_done", seId, 1'b0);
        checkOutput("si_id_done", siId, 1'b0);
        checkOutput("busy_done", busy, 1'b1);
        checkOutput("valid_at_done", idsValid, 1'b0);
        sawDone = 1;
      end
      nextCycle();
    end
    checkOutput("done_seen", sawDone, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    bit sawDone;
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00);

    // Reset state
    #12;
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_se_id", seId, 1'b0);
    checkOutput("rst_si_id", siId, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_valid", idsValid, 1'b0);
`ifdef GON_SCAN_READBACK_EN
    checkOutput("rst_old_ids", oldIds, 8'h00);
`endif
    @(negedge clk);
    reset = 1'b1;
    nextCycle();

    // Plain load of 8'hA5: si_id 1,0,1,0,0,1,0,1, done in cycle 9
    $display("[TB] load A5, no hold");
    runLoad(8'hA5, 99, 0, 1'b0, 9);
    @(negedge clk);
    checkOutput("valid_after_a5", idsValid, 1'b1);
    checkOutput("busy_after_a5", busy, 1'b0);
    checkOutput("chain_a5", chainModel, 8'hA5);
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      @(negedge clk);
      checkOutput("valid_idle_hold", idsValid, 1'b1);
    end
    nextCycle();

    // Hold for 3 cycles after the 4th shift and a spurious start with 8'hFF mid-load
    $display("[TB] load A5 with hold and ignored start");
    runLoad(8'hA5, 4, 3, 1'b1, 12);
    @(negedge clk);
    checkOutput("chain_after_hold", chainModel, 8'hA5);
    checkOutput("valid_after_hold", idsValid, 1'b1);
    nextCycle();

    // Start coincident with done is ignored, start in the next cycle is accepted
    $display("[TB] start at done boundary");
    applyStimulus(1'b1, 1'b0, 8'h5A);
    nextCycle();
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b0, 1'b0, 8'h5A);
      nextCycle();
    end
    applyStimulus(1'b1, 1'b0, 8'hC3);
    @(negedge clk);
    checkOutput("bnd_done", done, 1'b1);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 8'h81);
    @(negedge clk);
    checkOutput("bnd_ignored_busy", busy, 1'b0);
    checkOutput("bnd_ignored_valid", idsValid, 1'b1);
    checkOutput("bnd_chain_5a", chainModel, 8'h5A);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    checkOutput("bnd_accept_busy", busy, 1'b1);
    checkOutput("bnd_accept_valid", idsValid, 1'b0);
    checkOutput("bnd_accept_se", seId, 1'b1);
    checkOutput("bnd_accept_si", siId, 1'b1);
    sawDone = 0;
    for (int i = 0; i < 20 && !sawDone; i++) begin
      nextCycle();
      @(negedge clk);
      if (done) sawDone = 1;
    end
    checkOutput("bnd_done_seen", sawDone, 1'b1);
    nextCycle();
    @(negedge clk);
    checkOutput("bnd_chain_81", chainModel, 8'h81);
    checkOutput("bnd_valid_81", idsValid, 1'b1);
    nextCycle();

    // Reset in the middle of shifting, then a clean reload of 8'h3C
    $display("[TB] reset mid-shift");
    applyStimulus(1'b1, 1'b0, 8'hA5);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 8'hA5);
    for (int i = 0; i < 4; i++) nextCycle();
    #2;
    reset = 1'b0;
    #1;
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_se_id", seId, 1'b0);
    checkOutput("abort_si_id", siId, 1'b0);
    checkOutput("abort_done", done, 1'b0);
    checkOutput("abort_valid", idsValid, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    nextCycle();
    @(negedge clk);
    checkOutput("post_rst_valid", idsValid, 1'b0);
    checkOutput("post_rst_busy", busy, 1'b0);
    nextCycle();
    runLoad(8'h3C, 99, 0, 1'b0, 9);
    @(negedge clk);
    checkOutput("reload_valid", idsValid, 1'b1);
    checkOutput("reload_chain", chainModel, 8'h3C);
    nextCycle();

`ifdef GON_SCAN_READBACK_EN
    // Chain preloaded with 8'hA5, then loading 8'h3C reads the old table back
    $display("[TB] readback");
    runLoad(8'hA5, 99, 0, 1'b0, 9);
    runLoad(8'h3C, 99, 0, 1'b0, 9);
    @(negedge clk);
    checkOutput("old_ids", oldIds, 8'hA5);
    checkOutput("rb_chain", chainModel, 8'h3C);
    nextCycle();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/gon_scan_cfg_ctrl.md
GON_SCAN_CFG_CTRL -- requirements
Module: gon_scan_cfg_ctrl

Interface
REQ-001 SHALL have parameter NUM_MCC, default 12, meaning number of multicast controllers on the ID scan chain.
REQ-002 SHALL have parameter TAG_WIDTH, default 4, meaning ID bits per multicast controller.
REQ-003 SHALL define L = NUM_MCC*TAG_WIDTH as total chain length, with counter width $clog2(L+1).
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 SHALL have port start  input  1  one-cycle request to load a new ID table.
REQ-007 SHALL have port ids_in  input  L  flat ID table; bit k is destined for chain position k (position 0 nearest si_id).
REQ-008 SHALL have port hold  input  1  pause shifting while high.
REQ-009 SHALL have port so_id  input  1  scan-out of last chain element.
REQ-010 SHALL have port se_id  output  1  scan enable to every controller in the chain.
REQ-011 SHALL have port si_id  output  1  serial data into chain position 0.
REQ-012 SHALL have port busy  output  1  high from accepted start until done.
REQ-013 SHALL have port done  output  1  one-cycle pulse when load completes.
REQ-014 SHALL have port ids_valid  output  1  chain holds a fully loaded table; multicast data issue is permitted only while high.

Function
REQ-015 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-016 In IDLE, start=1 SHALL latch ids_in into a shadow register, clear bit counter to 0, clear ids_valid, and go to SHIFT next cycle.
REQ-017 In SHIFT with hold=0, SHALL drive se_id=1 and si_id=shadow[L-1-cnt], then increment cnt (MSB first).
REQ-018 In SHIFT with hold=1, SHALL drive se_id=0, keep cnt and si_id stable, and stay in SHIFT.
REQ-019 SHALL leave SHIFT for DONE on the cycle with cnt==L-1 and hold=0, giving exactly L enabled shift cycles.
REQ-020 In DONE, SHALL assert done=1 for one cycle, set ids_valid=1 on the next edge, and return to IDLE.
REQ-021 Latency with hold=0: start sampled at edge 0; se_id high for cycles 1..L; done high in cycle L+1; ids_valid high from cycle L+2.
REQ-022 SHALL ignore start while busy; the shadow register and ids_in changes have no effect mid-load.
REQ-023 busy SHALL equal (state != IDLE); se_id SHALL be 0 outside SHIFT; si_id SHALL be 0 when se_id=0 except during hold.
REQ-024 A start arriving in the same cycle as done SHALL be ignored; a start in the first IDLE cycle after DONE SHALL be accepted.
REQ-025 ids_valid SHALL stay high across idle cycles until the next accepted start.

Reset
REQ-026 reset=0 SHALL asynchronously force state=IDLE, cnt=0, shadow=0, se_id=0, si_id=0, busy=0, done=0, ids_valid=0.
REQ-027 Reset asserted mid-SHIFT SHALL abort the load; after release, ids_valid stays 0 until a full new load completes.

Configuration
REQ-028 Macro GON_SCAN_READBACK_EN SHALL, when defined, add output old_ids [L-1:0] and capture so_id into old_ids on each enabled shift cycle (shift-in at bit 0, so after L shifts old_ids equals the previous chain contents in position order); old_ids resets to 0 and is held while idle.
REQ-029 Without GON_SCAN_READBACK_EN, SHALL omit old_ids and ignore so_id; all other behaviour is identical.

Verification (NUM_MCC=2, TAG_WIDTH=4, L=8)
REQ-030 start with ids_in=8'hA5, hold=0 -> se_id high 8 cycles, si_id sequence 1,0,1,0,0,1,0,1, done in cycle 9, ids_valid from cycle 10.
REQ-031 Same load with hold=1 for 3 cycles after 4th shift -> se_id low 3 cycles, si_id held, total 8 shifts, done in cycle 12.
REQ-032 Second start pulsed during SHIFT with ids_in=8'hFF -> ignored; chain receives 8'hA5; busy stays high until done.
REQ-033 reset=0 at shift 5 then released, ids_valid=0 -> new start with 8'h3C completes in 9 cycles, ids_valid=1.
REQ-034 With GON_SCAN_READBACK_EN, chain model preloaded 8'hA5, load 8'h3C -> old_ids=8'hA5 at done.
REQ-035 start coincident with done -> ignored; start next cycle -> accepted, busy=1, ids_valid=0.
